instr_sequencer: RTL

- Instruction fetch/issue unit that drives the accumulator executor's code/in_data interface.
- Reads a byte-wide program memory with a 1-cycle synchronous read.
- Decodes 1- and 2-byte instructions and presents code + operand to the executor with a valid/ready handshake.
- Owns the program counter and implements the sleep stall, so the executor never free-runs on a stale code.

---
 rtl/instr_sequencer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/instr_sequencer.sv
// Instruction fetch/issue unit for the accumulator executor.
// Fetches 1- and 2-byte instructions from a byte-wide program memory with a
// 1-cycle synchronous read, presents code/in_data with a valid/ready handshake
// and stalls for SLEEP_CYCLES after an issued sleep.
// Optional feature: define INSTR_SEQ_JUMP_EN to make 0x0E a 2-byte jmp that
// loads pc from its operand and is never issued to the executor.
module instr_sequencer #(
  parameter int unsigned PC_W         = 8,
  parameter int unsigned START_ADDR   = 0,
  parameter int unsigned SLEEP_CYCLES = 10000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  output logic [PC_W-1:0] pm_addr,
  output logic            pm_rd,
  input  logic [7:0]      pm_rdata,
  output logic [7:0]      code,
  output logic [7:0]      in_data,
  output logic            issue_valid,
  input  logic            issue_ready,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            illegal
);

  localparam logic [PC_W-1:0] StartPc   = PC_W'(START_ADDR);
  localparam logic [PC_W-1:0] PcOne     = PC_W'(1);
  localparam bit              SleepEn   = (SLEEP_CYCLES != 0);
  localparam logic [24:0]     SleepLoad = SleepEn ? 25'(SLEEP_CYCLES - 1) : 25'd0;

  localparam logic [7:0] OpNop     = 8'h00;
  localparam logic [7:0] OpLoadRom = 8'h01;
  localparam logic [7:0] OpLoadNum = 8'h02;
  localparam logic [7:0] OpOutRom  = 8'h03;
  localparam logic [7:0] OpClr     = 8'h04;
  localparam logic [7:0] OpInc     = 8'h05;
  localparam logic [7:0] OpSleep   = 8'h0A;
  localparam logic [7:0] OpDec     = 8'h0C;
  localparam logic [7:0] OpOut     = 8'h0D;
`ifdef INSTR_SEQ_JUMP_EN
  localparam logic [7:0] OpJmp     = 8'h0E;
`endif

  typedef enum logic [2:0] {
    StIdle, StFetchOp, StDecodeOp, StFetchArg, StDecodeArg, StIssue, StSleep
  } state_e;

  state_e      state_q;
  logic [7:0]  opcode_q;
  logic [24:0] sleep_cnt_q;

  function automatic logic op_two_byte(input logic [7:0] op);
    logic r;
    r = (op == OpLoadRom) || (op == OpLoadNum) || (op == OpOutRom);
`ifdef INSTR_SEQ_JUMP_EN
    r = r || (op == OpJmp);
`endif
    return r;
  endfunction

  function automatic logic op_one_byte(input logic [7:0] op);
    return (op == OpClr) || (op == OpInc) || (op == OpSleep) || (op == OpDec) || (op == OpOut);
  endfunction

  // Undefined opcodes flag in the decode cycle itself, while pm_rdata holds them
  always_comb begin
    illegal = (state_q == StDecodeOp) && !op_two_byte(pm_rdata) && !op_one_byte(pm_rdata)
              && (pm_rdata != OpNop);
  end

  assign busy = (state_q != StIdle);

  // Sequencer FSM with registered memory and executor outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      pc          <= StartPc;
      pm_addr     <= StartPc;
      pm_rd       <= 1'b0;
      code        <= 8'h00;
      in_data     <= 8'h00;
      issue_valid <= 1'b0;
      opcode_q    <= 8'h00;
      sleep_cnt_q <= 25'd0;
    end else begin
      pm_rd <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (run) begin
            state_q <= StFetchOp;
            pm_rd   <= 1'b1;
            pm_addr <= pc;
          end
        end
        StFetchOp:  state_q <= StDecodeOp;
        StFetchArg: state_q <= StDecodeArg;
        StDecodeOp: begin
          opcode_q <= pm_rdata;
          pc       <= pc + PcOne;
          if (op_two_byte(pm_rdata)) begin
            state_q <= StFetchArg;
            pm_rd   <= 1'b1;
            pm_addr <= pc + PcOne;
          end else if (op_one_byte(pm_rdata)) begin
            state_q     <= StIssue;
            issue_valid <= 1'b1;
            code        <= pm_rdata;
            in_data     <= 8'h00;
          end else if (run) begin
            // NOP and illegal opcodes are skipped without issuing
            state_q <= StFetchOp;
            pm_rd   <= 1'b1;
            pm_addr <= pc + PcOne;
          end else begin
            state_q <= StIdle;
          end
        end
        StDecodeArg: begin
`ifdef INSTR_SEQ_JUMP_EN
          if (opcode_q == OpJmp) begin
            pc      <= PC_W'(pm_rdata);
            pm_addr <= PC_W'(pm_rdata);
            if (run) begin
              state_q <= StFetchOp;
              pm_rd   <= 1'b1;
            end else begin
              state_q <= StIdle;
            end
          end else
`endif
          begin
            pc          <= pc + PcOne;
            state_q     <= StIssue;
            issue_valid <= 1'b1;
            code        <= opcode_q;
            in_data     <= pm_rdata;
          end
        end
        StIssue: begin
          // code/in_data stay put until the executor accepts them
          if (issue_ready) begin
            issue_valid <= 1'b0;
            code        <= 8'h00;
            in_data     <= 8'h00;
            if ((code == OpSleep) && SleepEn) begin
              state_q     <= StSleep;
              sleep_cnt_q <= SleepLoad;
            end else if (run) begin
              state_q <= StFetchOp;
              pm_rd   <= 1'b1;
              pm_addr <= pc;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        StSleep: begin
          if (sleep_cnt_q == 25'd0) begin
            if (run) begin
              state_q <= StFetchOp;
              pm_rd   <= 1'b1;
              pm_addr <= pc;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            sleep_cnt_q <= sleep_cnt_q - 25'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
